// File: rtl/mips_dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding, owner codes
// and default bus widths.
package mips_dmem_arb_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_ACK   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

endpackage

// File: rtl/mips_arb_pick.sv
// Combinational 2-way picker: chooses between the core and the debug port,
// either fixed priority (core first) or round-robin on the last owner.
module mips_arb_pick
    import mips_dmem_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic dbg_req,
    input  logic last_owner,
    input  logic rr_en,
    output logic grant_any,
    output logic grant_dbg
);

    // On a tie, round-robin hands the slot to whoever was not served last.
    always_comb begin
        grant_any = cpu_req | dbg_req;
        grant_dbg = dbg_req;
        if (cpu_req && dbg_req) begin
            grant_dbg = rr_en ? (last_owner == OWN_CPU) : 1'b0;
        end
    end

endmodule

// File: rtl/mips_dmem_arb.sv
// Data-memory arbiter between the MIPS load/store unit and the debug/loader port.
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed CPU priority.
module mips_dmem_arb
    import mips_dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

`ifdef DMEM_ARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    arb_state_t state;
    owner_t     owner;
    logic       op_we;
    logic       pick_any;
    logic       pick_dbg;

    // owner doubles as the round-robin pointer: it is rewritten on every grant.
    mips_arb_pick u_pick (
        .cpu_req    (cpu_req),
        .dbg_req    (dbg_req),
        .last_owner (owner),
        .rr_en      (RR_EN),
        .grant_any  (pick_any),
        .grant_dbg  (pick_dbg)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            owner     <= OWN_CPU;
            op_we     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
            cpu_ack   <= 1'b0;
            dbg_ack   <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            dbg_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (pick_any) begin
                        mem_en    <= 1'b1;
                        mem_we    <= pick_dbg ? dbg_we    : cpu_we;
                        op_we     <= pick_dbg ? dbg_we    : cpu_we;
                        mem_addr  <= pick_dbg ? dbg_addr  : cpu_addr;
                        mem_wdata <= pick_dbg ? dbg_wdata : cpu_wdata;
                        owner     <= owner_t'(pick_dbg);
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    state  <= ST_RESP;
                end
                // Read data is valid now; writes leave the requester's rdata untouched.
                ST_RESP: begin
                    if (owner == OWN_CPU) begin
                        if (!op_we) cpu_rdata <= mem_rdata;
                        cpu_ack <= 1'b1;
                    end else begin
                        if (!op_we) dbg_rdata <= mem_rdata;
                        dbg_ack <= 1'b1;
                    end
                    state <= ST_ACK;
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_dmem_arb.sv
// Self-checking bench for mips_dmem_arb: directed steps feeding an ack scoreboard,
// with a behavioural synchronous RAM standing in for mips_d_mem.
module tb_mips_dmem_arb;

`ifdef DMEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [9:0]  cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic        dbg_req = 1'b0;
    logic        dbg_we = 1'b0;
    logic [9:0]  dbg_addr = '0;
    logic [31:0] dbg_wdata = '0;
    logic [31:0] dbg_rdata;
    logic        dbg_ack;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic [31:0] mem [0:1023];

    typedef struct packed {
        logic        own_dbg;
        logic [31:0] data;
        logic [31:0] ack_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   cpu_ack_cnt = 0;
    int   dbg_ack_cnt = 0;

    mips_dmem_arb dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_rdata (dbg_rdata),
        .dbg_ack   (dbg_ack),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory holds mem[i] = i while reset is low, giving known read data.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'(i);
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check_output(input string tag, input logic [127:0] observed,
                                input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Every ack pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && (cpu_ack || dbg_ack)) begin
            exp_t e;
            if (cpu_ack) cpu_ack_cnt++;
            if (dbg_ack) dbg_ack_cnt++;
            check_output("ack_one_hot", 128'(cpu_ack & dbg_ack), 128'(0));
            if (exp_q.size() == 0) begin
                check_output("unexpected_ack", 128'(1), 128'(0));
            end else begin
                e = exp_q.pop_front();
                check_output("ack_owner", 128'(dbg_ack), 128'(e.own_dbg));
                check_output(e.own_dbg ? "dbg_rdata" : "cpu_rdata",
                             128'(e.own_dbg ? dbg_rdata : cpu_rdata), 128'(e.data));
                check_output("ack_cycle", 128'(cyc), 128'(e.ack_cyc));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic dbg, input logic we, input logic [9:0] addr,
                                  input logic [31:0] wdata);
        if (dbg) begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
    endtask

    task automatic expect_ack(input logic dbg, input logic [31:0] data, input int lat);
        exp_t e;
        e.own_dbg = dbg;
        e.data    = data;
        e.ack_cyc = 32'(cyc + lat);
        exp_q.push_back(e);
    endtask

    task automatic wait_q(input int target, input int max_cyc, input string tag);
        int n = 0;
        while (exp_q.size() > target && n < max_cyc) begin
            tick(1);
            n++;
        end
        if (exp_q.size() > target) check_output(tag, 128'(exp_q.size()), 128'(target));
    endtask

    task automatic wait_cnt(input logic dbg, input int target, input int max_cyc);
        int n = 0;
        while ((dbg ? dbg_ack_cnt : cpu_ack_cnt) < target && n < max_cyc) begin
            tick(1);
            n++;
        end
        if ((dbg ? dbg_ack_cnt : cpu_ack_cnt) < target)
            check_output(dbg ? "dbg_cnt_timeout" : "cpu_cnt_timeout",
                         128'(dbg ? dbg_ack_cnt : cpu_ack_cnt), 128'(target));
    endtask

    initial begin
        int cstart;
        int dstart;
        int c_left;
        int d_left;
        int t;
        logic last_dbg;
        logic g_dbg;

        // Reset state, then a reset pulse in the middle of a CPU read.
        tick(3);
        check_output("reset_outputs",
                     128'({mem_en, mem_we, mem_addr, mem_wdata, cpu_ack, dbg_ack, cpu_rdata, dbg_rdata}),
                     128'(0));
        rst = 1'b1;
        tick(1);
        apply_stimulus(1'b0, 1'b0, 10'd3, 32'h0);
        tick(1);
        check_output("reset_issue_en", 128'({mem_en, mem_addr}), 128'({1'b1, 10'd3}));
        #2;
        rst = 1'b0;
        #1;
        check_output("reset_async_clear",
                     128'({mem_en, mem_we, mem_addr, mem_wdata, cpu_ack, dbg_ack}), 128'(0));
        cpu_req = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(6);
        check_output("reset_no_ack", 128'(cpu_ack_cnt), 128'(0));

        // CPU write then read-back of address 5.
        apply_stimulus(1'b0, 1'b1, 10'd5, 32'hDEADBEEF);
        expect_ack(1'b0, 32'h0, 3);
        tick(1);
        check_output("wr_cmd", 128'({mem_en, mem_we, mem_addr, mem_wdata}),
                     128'({1'b1, 1'b1, 10'd5, 32'hDEADBEEF}));
        tick(1);
        check_output("wr_cmd_drop", 128'({mem_en, mem_we}), 128'(0));
        wait_q(0, 20, "wr_timeout");
        cpu_req = 1'b0;
        apply_stimulus(1'b0, 1'b0, 10'd5, 32'h0);
        expect_ack(1'b0, 32'hDEADBEEF, 3);
        wait_q(0, 20, "rd_timeout");
        cpu_req = 1'b0;

        // Debug read of preloaded address 8; the core must see no ack.
        cstart = cpu_ack_cnt;
        apply_stimulus(1'b1, 1'b0, 10'd8, 32'h0);
        expect_ack(1'b1, 32'h8, 3);
        wait_q(0, 20, "dbg_timeout");
        dbg_req = 1'b0;
        check_output("dbg_no_cpu_ack", 128'(cpu_ack_cnt), 128'(cstart));

        // Simultaneous requests; last grant was debug so the core wins in either mode.
        apply_stimulus(1'b0, 1'b0, 10'd1, 32'h0);
        apply_stimulus(1'b1, 1'b0, 10'd2, 32'h0);
        expect_ack(1'b0, 32'h1, 3);
        expect_ack(1'b1, 32'h2, 7);
        wait_q(1, 20, "sim_cpu_timeout");
        cpu_req = 1'b0;
        wait_q(0, 20, "sim_dbg_timeout");
        dbg_req = 1'b0;

        // Sustained contention: 8 core reads of addr 16, 4 debug reads of addr 9.
        cstart = cpu_ack_cnt;
        dstart = dbg_ack_cnt;
        c_left = 8;
        d_left = 4;
        last_dbg = 1'b1;
        t = 1;
        while (c_left > 0 || d_left > 0) begin
            if (c_left > 0 && d_left > 0) g_dbg = RR_EN ? !last_dbg : 1'b0;
            else g_dbg = (d_left > 0);
            expect_ack(g_dbg, g_dbg ? 32'd9 : 32'd16, t + 2);
            last_dbg = g_dbg;
            if (g_dbg) d_left--;
            else c_left--;
            t += 4;
        end
        apply_stimulus(1'b0, 1'b0, 10'd16, 32'h0);
        apply_stimulus(1'b1, 1'b0, 10'd9, 32'h0);
        fork
            begin
                wait_cnt(1'b0, cstart + 8, 100);
                cpu_req = 1'b0;
            end
            begin
                wait_cnt(1'b1, dstart + 4, 100);
                dbg_req = 1'b0;
            end
        join
        wait_q(0, 20, "rr_timeout");
        check_output("rr_cpu_count", 128'(cpu_ack_cnt), 128'(cstart + 8));
        check_output("rr_dbg_count", 128'(dbg_ack_cnt), 128'(dstart + 4));

        // Core drops its request while the access is in flight.
        cstart = cpu_ack_cnt;
        apply_stimulus(1'b0, 1'b0, 10'd5, 32'h0);
        expect_ack(1'b0, 32'hDEADBEEF, 3);
        tick(2);
        cpu_req = 1'b0;
        cpu_addr = 10'd0;
        tick(8);
        check_output("drop_single_ack", 128'(cpu_ack_cnt), 128'(cstart + 1));
        check_output("drop_q_empty", 128'(exp_q.size()), 128'(0));
        apply_stimulus(1'b1, 1'b0, 10'd5, 32'h0);
        expect_ack(1'b1, 32'hDEADBEEF, 3);
        wait_q(0, 20, "post_drop_timeout");
        dbg_req = 1'b0;
        tick(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
